route_sequencer: RTL

ROUTE_SEQUENCER -- requirements
Module: route_sequencer

---
 rtl/route_sequencer_pkg.sv | 34 +++
 rtl/route_sequencer_if.sv | 36 +++
 rtl/route_sequencer_step_timer.sv | 33 +++
 rtl/route_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/route_sequencer_pkg.sv
// Purpose : shared turn codes, route limits and FSM state encoding for route_sequencer.
// Latency : n/a (declarations only).
// Backpressure : n/a.
package route_sequencer_pkg;

  // Turn codes as presented on cmd_dir
  localparam logic [2:0] STRAIGHT = 3'd0;
  localparam logic [2:0] REVERSE  = 3'd1;
  localparam logic [2:0] RIGHT    = 3'd2;
  localparam logic [2:0] LEFT     = 3'd3;
  localparam logic [2:0] STOP     = 3'd4;

  localparam logic [5:0] NODE_MAX  = 6'd36;
  localparam int         MAX_STEPS = 10;
  // Highest step index; also the largest plan_len that still leaves room for the stop code
  localparam logic [3:0] STEP_MAX  = 4'(MAX_STEPS - 1);

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    SETTLE,
    CAPTURE,
    ISSUE,
    WAIT_ACK,
    WAIT_NODE,
    FINISH,
    ERROR
  } state_t;

  function automatic logic node_ok(input logic [5:0] n);
    return n <= NODE_MAX;
  endfunction

endpackage

// File: rtl/route_sequencer_if.sv
// Purpose : planner, sensor, motor and status signals of route_sequencer bundled as one interface.
// Latency : n/a (wiring only).
// Backpressure : none; turn_done is the only acknowledge and node_det the only progress pulse.
// Ports   : master = environment side (drives requests/planner/sensors),
//           slave  = sequencer side (drives planner nodes, commands, status).
interface route_sequencer_if;
  import route_sequencer_pkg::*;

  logic                        start_req;
  logic [5:0]                  start_node;
  logic [5:0]                  end_node;
  logic [3*MAX_STEPS-1:0]      dir_bus;
  logic [3:0]                  plan_len;
  logic                        node_det;
  logic                        turn_done;

  logic [5:0]                  plan_start;
  logic [5:0]                  plan_end;
  logic                        cmd_valid;
  logic [2:0]                  cmd_dir;
  logic [3:0]                  cur_step;
  logic                        busy;
  logic                        done;
  logic                        err;

  modport master (
    output start_req, start_node, end_node, dir_bus, plan_len, node_det, turn_done,
    input  plan_start, plan_end, cmd_valid, cmd_dir, cur_step, busy, done, err
  );

  modport slave (
    input  start_req, start_node, end_node, dir_bus, plan_len, node_det, turn_done,
    output plan_start, plan_end, cmd_valid, cmd_dir, cur_step, busy, done, err
  );

endinterface

// File: rtl/route_sequencer_step_timer.sv
// Purpose : cycle counter that flags when LIMIT enabled cycles have elapsed since clear.
// Latency : expire is combinational in the LIMIT-th enabled cycle after clear.
// Backpressure : none; holds its count at LIMIT-1 instead of wrapping.
// Ports   : clk, rst_n (async active-low), clear (sync zero), enable (count this cycle), expire.
module step_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int         W    = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Count value k means k enabled cycles already passed, so this is the LIMIT-th one
  assign expire = enable && (cnt_q == LAST);

endmodule

// File: rtl/route_sequencer.sv
// Purpose : drives the path planner, then steps through its turn codes one junction at a time.
// Latency : first command SETTLE_CYC+3 cycles after start_req; each later one the cycle after node_det.
// Backpressure : waits indefinitely for node_det, at most ACK_TIMEOUT cycles for turn_done.
// Ports   : clk, rst_n (async assert, synchronised release), bus (route_sequencer_if.slave).
module route_sequencer
  import route_sequencer_pkg::*;
#(
  parameter int SETTLE_CYC  = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  route_sequencer_if.slave   bus
);

  localparam int           SW          = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

  // Reset asserts straight through but releases two edges later, so no flop sees
  // a release racing the clock.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];

  state_t                     state_q, state_d;
  logic [5:0]                 plan_start_q, plan_end_q;
  logic [MAX_STEPS-1:0][2:0]  codes_q;
  logic [3:0]                 plan_len_q;
  logic [3:0]                 cur_step_q;
  logic [SW-1:0]              settle_cnt_q;

  logic       latch_nodes;
  logic       capture;
  logic       step_inc;
  logic       settle_clr;
  logic       settle_en;
  logic       tmr_clr;
  logic       tmr_en;
  logic       tmr_expire;
  logic       cmd_valid;
  logic [2:0] cmd_dir;
  logic [2:0] cur_code;
  logic       issue_ok;

  assign cur_code = codes_q[cur_step_q];
  // A code is issuable only if it is a defined turn, and the slot at plan_len must be the stop
  assign issue_ok = (cur_code <= STOP) &&
                    ((cur_step_q != plan_len_q) || (cur_code == STOP));

  step_timer #(
    .LIMIT (ACK_TIMEOUT)
  ) u_ack_timer (
    .clk    (clk),
    .rst_n  (rst_int_n),
    .clear  (tmr_clr),
    .enable (tmr_en),
    .expire (tmr_expire)
  );

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    latch_nodes = 1'b0;
    capture     = 1'b0;
    step_inc    = 1'b0;
    settle_clr  = 1'b0;
    settle_en   = 1'b0;
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;
    cmd_valid   = 1'b0;
    cmd_dir     = STRAIGHT;

    unique case (state_q)
      IDLE, FINISH, ERROR: begin
        if (bus.start_req) begin
          latch_nodes = 1'b1;
          state_d     = LOAD;
        end
      end

      LOAD: begin
        settle_clr = 1'b1;
        if (!node_ok(plan_start_q) || !node_ok(plan_end_q) || (plan_start_q == plan_end_q)) begin
          state_d = ERROR;
        end else begin
          state_d = SETTLE;
        end
      end

      SETTLE: begin
        settle_en = 1'b1;
        if (settle_cnt_q == SETTLE_LAST) begin
          state_d = CAPTURE;
        end
      end

      CAPTURE: begin
        capture = 1'b1;
        if ((bus.plan_len == 4'd0) || (bus.plan_len > STEP_MAX)) begin
          state_d = ERROR;
        end else begin
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        tmr_clr = 1'b1;
        if (issue_ok) begin
          cmd_valid = 1'b1;
          cmd_dir   = cur_code;
          state_d   = WAIT_ACK;
        end else begin
          state_d   = ERROR;
        end
      end

      WAIT_ACK: begin
        tmr_en = 1'b1;
        // turn_done wins over both a concurrent node_det and a same-cycle expiry
        if (bus.turn_done) begin
          if (cur_code == STOP) begin
            state_d = FINISH;
          end else begin
            step_inc = 1'b1;
            state_d  = WAIT_NODE;
          end
        end else if (tmr_expire) begin
          state_d = ERROR;
        end
      end

      WAIT_NODE: begin
        if (bus.node_det) begin
          state_d = ISSUE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      plan_start_q <= '0;
      plan_end_q   <= '0;
      codes_q      <= {MAX_STEPS{STOP}};
      plan_len_q   <= '0;
      cur_step_q   <= '0;
      settle_cnt_q <= '0;
    end else begin
      if (latch_nodes) begin
        plan_start_q <= bus.start_node;
        plan_end_q   <= bus.end_node;
      end

      if (settle_clr) begin
        settle_cnt_q <= '0;
      end else if (settle_en && (settle_cnt_q != SETTLE_LAST)) begin
        settle_cnt_q <= settle_cnt_q + 1'b1;
      end

      if (capture) begin
        codes_q    <= bus.dir_bus;
        plan_len_q <= bus.plan_len;
        cur_step_q <= '0;
      end else if (step_inc && (cur_step_q != STEP_MAX)) begin
        cur_step_q <= cur_step_q + 1'b1;
      end
    end
  end

  assign bus.plan_start = plan_start_q;
  assign bus.plan_end   = plan_end_q;
  assign bus.cmd_valid  = cmd_valid;
  assign bus.cmd_dir    = cmd_dir;
  assign bus.cur_step   = cur_step_q;
  assign bus.busy       = !((state_q == IDLE) || (state_q == FINISH) || (state_q == ERROR));
  assign bus.done       = (state_q == FINISH);
  assign bus.err        = (state_q == ERROR);

endmodule
